// File: rtl/bf16_pkg.sv
// Shared BF16 types for the multiplier completion stage.
//   bf16_t      packed BF16 word {sign, exp, frac}
//   cls_e       special-case class of an operand pair
//   sb_entry_t  one sideband queue entry {sign, ea, eb, cls}
//   classify()  derives the pair class from both raw operands
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_e;

    typedef struct packed {
        logic       sign;
        logic [7:0] ea;
        logic [7:0] eb;
        cls_e       cls;
    } sb_entry_t;

    localparam int          BF16_BIAS    = 127;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

    // Subnormal inputs count as zero. NaN wins over everything, and
    // INF x ZERO is also an invalid operation that yields NaN.
    function automatic cls_e classify(input bf16_t a, input bf16_t b);
        logic a_max;
        logic b_max;
        logic a_zero;
        logic b_zero;
        cls_e cls;
        a_max  = (a.exp == BF16_EXP_MAX);
        b_max  = (b.exp == BF16_EXP_MAX);
        a_zero = (a.exp == 8'h00);
        b_zero = (b.exp == 8'h00);
        if ((a_max && a.frac != 7'h0) || (b_max && b.frac != 7'h0) ||
            (a_max && b_zero) || (b_max && a_zero)) begin
            cls = CLS_NAN;
        end else if (a_max || b_max) begin
            cls = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/bf16_sideband_fifo.sv
// Sideband queue holding {sign, ea, eb, cls} per issued operand pair until
// its mantissa product arrives.
//   clk, nRST   clock, asynchronous active-low reset
//   flush       synchronous clear of pointers and count
//   push, pop   already-qualified write/read strobes (never push when full
//               unless popping in the same cycle, never pop when empty)
//   wdata       entry to write
//   rdata       oldest entry (valid while !empty)
//   full, empty, count   occupancy status
module bf16_sideband_fifo
    import bf16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  sb_entry_t                  wdata,
    output sb_entry_t                  rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    // NOTE: storage is not reset; an entry is only read after it was written,
    // and the pointers/count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/bf16_mul_normalize.sv
// Completion stage of the BF16 multiplier: queues sign/exponents/class of
// each issued pair, pairs each arriving mantissa product with the oldest
// entry, then normalizes, rounds to nearest-even and packs the result.
//   clk, nRST      clock, asynchronous active-low reset
//   in_valid       operand pair issued; a_in, b_in are the BF16 operands
//   mant_valid     mantissa product valid; mant_in = {1,fa}*{1,fb} in [1,4)
//   flush          synchronous clear of queue and pipeline (errors kept)
//   out_valid      one-cycle pulse per result, out_bf16 the packed product
//   q_full         queue holds DEPTH entries
//   err_overflow   sticky: push dropped because queue full
//   err_underflow  sticky: product arrived with empty queue, dropped
module bf16_mul_normalize
    import bf16_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [15:0] QNAN  = BF16_QNAN
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        in_valid,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        mant_valid,
    input  logic [15:0] mant_in,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_bf16,
    output logic        q_full,
    output logic        err_overflow,
    output logic        err_underflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_entry_t     wr_entry;
    sb_entry_t     rd_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_ok;
    logic          push_ok;

    // A pop frees a slot in the same edge, so a full queue still accepts
    // a push when a product is consumed alongside it. Flush overrides both.
    assign pop_ok  = mant_valid && !fifo_empty && !flush;
    assign push_ok = in_valid && (!fifo_full || pop_ok) && !flush;

    always_comb begin
        wr_entry.sign = a_in[15] ^ b_in[15];
        wr_entry.ea   = a_in[14:7];
        wr_entry.eb   = b_in[14:7];
        wr_entry.cls  = classify(bf16_t'(a_in), bf16_t'(b_in));
    end

    bf16_sideband_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nRST  (nRST),
        .flush (flush),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign q_full = (fifo_count == CW'(DEPTH));

    // Stage 1: pick the normalization window and derive the round bit.
    logic [6:0] nf;
    logic       ng;
    logic       nst;
    logic       nn;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        nf  = mant_in[13:7];
        ng  = mant_in[6];
        nst = |mant_in[5:0];
        nn  = 1'b0;
        if (mant_in[15]) begin
            nf  = mant_in[14:8];
            ng  = mant_in[7];
            nst = |mant_in[6:0];
            nn  = 1'b1;
        end
    end

    logic       s1_valid;
    logic       s1_sign;
    logic [7:0] s1_ea;
    logic [7:0] s1_eb;
    cls_e       s1_cls;
    logic [6:0] s1_f;
    logic       s1_rnd;
    logic       s1_n;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_cls   <= CLS_NORM;
            s1_f     <= '0;
            s1_rnd   <= 1'b0;
            s1_n     <= 1'b0;
        end else begin
            s1_valid <= pop_ok;
            if (pop_ok) begin
                s1_sign <= rd_entry.sign;
                s1_ea   <= rd_entry.ea;
                s1_eb   <= rd_entry.eb;
                s1_cls  <= rd_entry.cls;
                s1_f    <= nf;
                s1_rnd  <= ng & (nst | nf[0]);
                s1_n    <= nn;
            end
        end
    end

    // Stage 2: apply rounding, compute the biased exponent, pack.
    logic [7:0]        f_sum;
    logic signed [9:0] e_s;
    bf16_t             res;

    always_comb begin
        f_sum = {1'b0, s1_f} + {7'b0, s1_rnd};
        // Unsigned 10-bit sum stays below 1024; reinterpreting it as signed
        // gives the true exponent in the range the operands can produce.
        e_s   = $signed({2'b00, s1_ea} + {2'b00, s1_eb} + {9'b0, s1_n}
                        + {9'b0, f_sum[7]} - 10'(BF16_BIAS));
        res   = '{sign: s1_sign, exp: e_s[7:0], frac: f_sum[6:0]};
        case (s1_cls)
            CLS_NAN:  res = bf16_t'(QNAN);
            CLS_INF:  res = '{sign: s1_sign, exp: BF16_EXP_MAX, frac: 7'h0};
            CLS_ZERO: res = '{sign: s1_sign, exp: 8'h00, frac: 7'h0};
            default: begin
                if (e_s >= 10'sd255) begin
                    res = '{sign: s1_sign, exp: BF16_EXP_MAX, frac: 7'h0};
                end else if (e_s <= 10'sd0) begin
                    // Flush-to-zero: no subnormal results.
                    res = '{sign: s1_sign, exp: 8'h00, frac: 7'h0};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            out_valid     <= 1'b0;
            out_bf16      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            out_valid <= s1_valid && !flush;
            if (s1_valid) begin
                out_bf16 <= res;
            end
            if (in_valid && fifo_full && !pop_ok && !flush) begin
                err_overflow <= 1'b1;
            end
            if (mant_valid && fifo_empty && !flush) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
